opcode_buffer: RTL and testbench
================================

Name: opcode_buffer

Overview:
- Instruction-fetch buffer between the CPU front end and a byte-wide memory port.
- On a load request it latches the instruction pointer and reads DATA_WIDTH/8 consecutive bytes, one per memory handshake.
- It assembles them big-endian into a DATA_WIDTH-bit opcode and holds the opcode stable for the decode stage until the next fetch completes.

Parameters:
- ADDR_WIDTH, 32, width of ip and mem_addr.
- DATA_WIDTH, 32, opcode width; must be a multiple of 8. NBYTES = DATA_WIDTH/8.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ip  input  ADDR_WIDTH  byte address of the instruction to fetch.
- start_loading  input  1  level request to fetch at ip; sampled only when idle.
- mem_data  input  8  byte returned by memory.
- mem_busy  input  1  memory is working; mem_data is valid in a WAIT cycle with mem_busy=0.
- busy  output  1  fetch in progress; opcode is not yet updated.
- opcode  output  DATA_WIDTH  last completely fetched instruction.
- mem_addr  output  ADDR_WIDTH  byte address driven to memory.
- mem_request  output  1  one-cycle read strobe to memory.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, opcode=0, mem_addr=0, mem_request=0, byte index k=0, base=0. Reset during a fetch aborts it; partial bytes are discarded and opcode becomes 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - start_loading=1 at an edge: base<=ip, k<=0, busy<=1, mem_addr<=ip, mem_request<=1, go to ISSUE.
  - Otherwise remain in IDLE; busy=0, mem_request=0.
- ISSUE (one cycle): at the next edge mem_request<=0, go to WAIT. mem_addr holds.
- WAIT:
  - Each edge with mem_busy=1: stay in WAIT.
  - Edge with mem_busy=0: capture mem_data into byte k.
  - If k<NBYTES-1: k<=k+1, mem_addr<=base+k+1, mem_request<=1, go to ISSUE.
  - If k=NBYTES-1: opcode<=assembled word including this byte, busy<=0, go to IDLE.
- Byte order is big-endian: the byte at base lands in opcode[DATA_WIDTH-1:DATA_WIDTH-8] and the byte at base+NBYTES-1 in opcode[7:0].
- Latency with mem_busy always 0 and NBYTES=4:
  - Start accepted at edge E0.
  - Byte k captured at edge E(2k+2).
  - busy falls and the new opcode is visible after E8.
  - mem_request is high in the cycles after E0, E2, E4 and E6.
- Throughput:
  - start_loading held high restarts a fetch on the first edge after completion, using ip at that edge. The caller advances ip as it consumes the opcode.
  - Minimum fetch period is 9 cycles: 8 busy cycles plus one IDLE cycle.
- start_loading and ip changes while busy are ignored; the latched base is used.
- Address arithmetic: base+k wraps modulo 2^ADDR_WIDTH. Unaligned ip is legal and needs no special handling.
- opcode never changes except at fetch completion or reset. No glitch of partial data is ever visible.

Optional Feature:
- Macro OPCODE_BUFFER_HIT_EN enables a one-entry hit bypass.
- When defined:
  - Keep a last_addr register and a valid flag, both cleared by reset; set them at every completion.
  - In IDLE, start_loading=1 with valid=1 and ip==last_addr issues no memory access, keeps busy=0, leaves opcode unchanged and stays IDLE.
- When undefined: every start_loading performs a full memory fetch.

Test Plan:
- Reset mid-fetch: assert reset during the WAIT of byte 2 -> busy=0, opcode=0, mem_request=0 immediately without a clock edge; the next fetch starts clean.
- Basic fetch, zero-wait memory: memory holds 0x20,0x01,0x00,0x05 at 0x0..0x3, start_loading=1 at ip=0 -> mem_addr 0,1,2,3 with one-cycle request strobes; busy high 8 cycles; opcode=0x20010005.
- Wait states: mem_busy held 1 for 3 cycles per byte, ip=0x100, bytes 0x08,0x00,0x00,0x10 -> opcode=0x08000010 after 20 busy cycles; opcode stays at its old value throughout.
- Ignored inputs: change ip from 0x4 to 0x40 and pulse start_loading mid-fetch -> fetch completes from 0x4..0x7; the new ip is used only after busy falls.
- Wrap-around: ip=0xFFFFFFFE -> mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Back-to-back: start_loading held high, ip stepped +4 on each busy fall -> consecutive opcodes from 0x0, 0x4, 0x8 with a 9-cycle period. With OPCODE_BUFFER_HIT_EN defined and ip not stepped -> no mem_request after the first fetch.

Source files
------------

// File: rtl/opcode_buffer_if.sv
// Byte-wide memory read port between the opcode buffer (master) and memory (slave).
interface opcode_buffer_if #(
   parameter int ADDR_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_request;
   logic [7:0]            mem_data;
   logic                  mem_busy;

   modport master (output mem_addr, output mem_request, input mem_data, input mem_busy);
   modport slave  (input mem_addr, input mem_request, output mem_data, output mem_busy);
endinterface

// File: rtl/opcode_buffer.sv
// Instruction-fetch buffer: reads DATA_WIDTH/8 bytes big-endian from a byte-wide memory port.
// Optional one-entry hit bypass enabled by defining OPCODE_BUFFER_HIT_EN.
module opcode_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] ip,
   input  logic                  start_loading,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] opcode,
   opcode_buffer_if.master       memBus
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t                state, stateNext;
   logic [IDX_W-1:0]      byteIdx, byteIdxNext;
   logic [ADDR_WIDTH-1:0] baseAddr, baseAddrNext;
   logic [ADDR_WIDTH-1:0] memAddrNext;
   logic                  memRequestNext;
   logic                  busyNext;
   logic [DATA_WIDTH-1:0] partial, partialNext;
   logic [DATA_WIDTH-1:0] opcodeNext;
   logic                  startAccept;

`ifdef OPCODE_BUFFER_HIT_EN
   logic [ADDR_WIDTH-1:0] lastAddr, lastAddrNext;
   logic                  hitValid, hitValidNext;

   // A repeat request for the opcode already held is satisfied without touching memory.
   assign startAccept = start_loading && !(hitValid && (ip == lastAddr));
`else
   assign startAccept = start_loading;
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      stateNext      = state;
      byteIdxNext    = byteIdx;
      baseAddrNext   = baseAddr;
      memAddrNext    = memBus.mem_addr;
      memRequestNext = 1'b0;
      busyNext       = busy;
      partialNext    = partial;
      opcodeNext     = opcode;
`ifdef OPCODE_BUFFER_HIT_EN
      lastAddrNext   = lastAddr;
      hitValidNext   = hitValid;
`endif

      case (state)
         IDLE: begin
            if (startAccept) begin
               baseAddrNext   = ip;
               byteIdxNext    = '0;
               busyNext       = 1'b1;
               memAddrNext    = ip;
               memRequestNext = 1'b1;
               stateNext      = ISSUE;
            end else begin
               busyNext = 1'b0;
            end
         end

         ISSUE: stateNext = WAIT;

         WAIT: begin
            if (!memBus.mem_busy) begin
               // Byte k lands k bytes below the top of the word (big-endian).
               for (int b = 0; b < NBYTES; b++) begin
                  if (b == NBYTES - 1 - int'(byteIdx)) partialNext[8*b +: 8] = memBus.mem_data;
               end

               if (int'(byteIdx) < NBYTES - 1) begin
                  byteIdxNext    = byteIdx + IDX_W'(1);
                  memAddrNext    = baseAddr + ADDR_WIDTH'(byteIdx) + ADDR_WIDTH'(1);
                  memRequestNext = 1'b1;
                  stateNext      = ISSUE;
               end else begin
                  opcodeNext = partialNext;
                  busyNext   = 1'b0;
                  stateNext  = IDLE;
`ifdef OPCODE_BUFFER_HIT_EN
                  lastAddrNext = baseAddr;
                  hitValidNext = 1'b1;
`endif
               end
            end
         end

         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         byteIdx            <= '0;
         baseAddr           <= '0;
         memBus.mem_addr    <= '0;
         memBus.mem_request <= 1'b0;
         busy               <= 1'b0;
         // NOTE: the assembly buffer is cleared too, so an aborted fetch leaves no stale bytes.
         partial            <= '0;
         opcode             <= '0;
`ifdef OPCODE_BUFFER_HIT_EN
         lastAddr           <= '0;
         hitValid           <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking updates make every register see the pre-edge values of the others.
         state              <= stateNext;
         byteIdx            <= byteIdxNext;
         baseAddr           <= baseAddrNext;
         memBus.mem_addr    <= memAddrNext;
         memBus.mem_request <= memRequestNext;
         busy               <= busyNext;
         partial            <= partialNext;
         opcode             <= opcodeNext;
`ifdef OPCODE_BUFFER_HIT_EN
         lastAddr           <= lastAddrNext;
         hitValid           <= hitValidNext;
`endif
      end
   end

endmodule

// File: tb/tb_opcode_buffer.sv
// Self-checking bench for opcode_buffer: behavioural byte memory plus a concatenation-based opcode model.
module tb_opcode_buffer;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] ip;
   logic          start_loading;
   logic          busy;
   logic [DW-1:0] opcode;

   opcode_buffer_if #(.ADDR_WIDTH(AW)) memBus ();

   opcode_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .reset         (reset),
      .ip            (ip),
      .start_loading (start_loading),
      .busy          (busy),
      .opcode        (opcode),
      .memBus        (memBus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]    memImg [logic [AW-1:0]];
   int            memWait = 0;
   int            waitLeft = 0;
   logic [AW-1:0] pendAddr = '0;

   // Results of the most recent do_fetch call.
   logic [AW-1:0] reqAddr [0:31];
   int            reqCount;
   int            busyCount;
   logic [31:0]   reqMask;
   bit            opcodeMoved;
   bit            pulseBad;
   bit            timedOut;

   function automatic logic [7:0] memByte(logic [AW-1:0] a);
      if (!memImg.exists(a)) memImg[a] = 8'($urandom);
      return memImg[a];
   endfunction

   // The opcode is simply the NB bytes from base upward, first byte most significant.
   function automatic logic [DW-1:0] expOpcode(logic [AW-1:0] base);
      logic [DW-1:0] w = '0;
      for (int i = 0; i < NB; i++) w = {w[DW-9:0], memByte(base + AW'(i))};
      return w;
   endfunction

   // Memory: after each request, memWait busy cycles, then one cycle with valid data.
   always @(negedge clk) begin
      if (memBus.mem_request) begin
         pendAddr        = memBus.mem_addr;
         waitLeft        = memWait;
         memBus.mem_busy = 1'b1;
         memBus.mem_data = 8'($urandom);
      end else if (waitLeft > 0) begin
         waitLeft--;
         memBus.mem_busy = 1'b1;
         memBus.mem_data = 8'($urandom);
      end else begin
         memBus.mem_busy = 1'b0;
         memBus.mem_data = memByte(pendAddr);
      end
   end

   task automatic do_fetch(input logic [AW-1:0] ipVal, input bit mutate);
      logic [DW-1:0] oldOp;
      bit            prevReq;
      int            n;
      @(negedge clk);
      ip            = ipVal;
      start_loading = 1'b1;
      oldOp         = opcode;
      reqCount = 0; busyCount = 0; reqMask = '0;
      opcodeMoved = 0; pulseBad = 0; timedOut = 0; prevReq = 0;
      @(negedge clk);
      start_loading = 1'b0;
      n = 0;
      while (busy && n < 400) begin
         if (opcode !== oldOp) opcodeMoved = 1;
         if (memBus.mem_request) begin
            if (reqCount < 32) reqAddr[reqCount] = memBus.mem_addr;
            if (busyCount < 32) reqMask[busyCount] = 1'b1;
            if (prevReq) pulseBad = 1;
            reqCount++;
         end
         prevReq = memBus.mem_request;
         if (mutate && busyCount == 3) begin
            ip            = ipVal + 32'h3C;
            start_loading = 1'b1;
         end
         if (mutate && busyCount == 5) start_loading = 1'b0;
         busyCount++;
         n++;
         @(negedge clk);
      end
      if (busy) timedOut = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start_loading = 1'b0; ip = '0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (opcode !== '0) begin errors++; $display("FAIL reset_opcode got %h want 0", opcode); end
      checks++; if (memBus.mem_request !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", memBus.mem_request); end
      checks++; if (memBus.mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", memBus.mem_addr); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_basic();
      memImg[32'h0] = 8'h20; memImg[32'h1] = 8'h01; memImg[32'h2] = 8'h00; memImg[32'h3] = 8'h05;
      memWait = 0;
      do_fetch(32'h0, 0);
      checks++; if (timedOut) begin errors++; $display("FAIL basic_timeout busy still %b want 0", busy); end
      checks++; if (busyCount !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", busyCount); end
      checks++; if (opcode !== 32'h20010005) begin errors++; $display("FAIL basic_opcode got %h want 20010005", opcode); end
      checks++; if (reqMask !== 32'h55) begin errors++; $display("FAIL basic_req_timing got %h want 55", reqMask); end
      checks++; if (pulseBad) begin errors++; $display("FAIL basic_req_pulse got long strobe want one-cycle"); end
      checks++; if (opcodeMoved) begin errors++; $display("FAIL basic_opcode_stable got change want stable"); end
      checks++; if (reqCount !== NB) begin errors++; $display("FAIL basic_req_count got %0d want %0d", reqCount, NB); end
      for (int i = 0; i < NB; i++) begin
         checks++;
         if (reqAddr[i] !== AW'(i)) begin errors++; $display("FAIL basic_addr%0d got %h want %h", i, reqAddr[i], i); end
      end
   endtask

   task automatic test_reset_mid_fetch();
      int seen = 0;
      int n = 0;
      memWait = 3;
      @(negedge clk);
      ip = 32'h200; start_loading = 1'b1;
      @(negedge clk);
      start_loading = 1'b0;
      while (seen < 3 && n < 100) begin
         if (memBus.mem_request) seen++;
         n++;
         @(negedge clk);
      end
      checks++; if (seen !== 3 || busy !== 1'b1) begin errors++; $display("FAIL midreset_setup got req %0d busy %b want 3 1", seen, busy); end
      #1 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
      checks++; if (opcode !== '0) begin errors++; $display("FAIL midreset_opcode got %h want 0", opcode); end
      checks++; if (memBus.mem_request !== 1'b0) begin errors++; $display("FAIL midreset_req got %b want 0", memBus.mem_request); end
      @(negedge clk);
      reset = 1'b0;
      memWait = 0;
      do_fetch(32'h200, 0);
      checks++; if (opcode !== expOpcode(32'h200)) begin errors++; $display("FAIL midreset_refetch got %h want %h", opcode, expOpcode(32'h200)); end
      checks++; if (reqAddr[0] !== 32'h200 || busyCount !== 8) begin errors++; $display("FAIL midreset_clean got addr %h cycles %0d want 200 8", reqAddr[0], busyCount); end
   endtask

   task automatic test_wait_states();
      memImg[32'h100] = 8'h08; memImg[32'h101] = 8'h00; memImg[32'h102] = 8'h00; memImg[32'h103] = 8'h10;
      memWait = 3;
      do_fetch(32'h100, 0);
      checks++; if (busyCount !== 20) begin errors++; $display("FAIL wait_busy_cycles got %0d want 20", busyCount); end
      checks++; if (opcode !== 32'h08000010) begin errors++; $display("FAIL wait_opcode got %h want 08000010", opcode); end
      checks++; if (opcodeMoved) begin errors++; $display("FAIL wait_opcode_stable got change want stable"); end
      memWait = 0;
   endtask

   task automatic test_ignored_inputs();
      memWait = 1;
      do_fetch(32'h4, 1);
      checks++; if (busyCount !== 12) begin errors++; $display("FAIL ignored_busy_cycles got %0d want 12", busyCount); end
      checks++; if (opcode !== expOpcode(32'h4)) begin errors++; $display("FAIL ignored_opcode got %h want %h", opcode, expOpcode(32'h4)); end
      for (int i = 0; i < NB; i++) begin
         checks++;
         if (reqAddr[i] !== AW'(4 + i)) begin errors++; $display("FAIL ignored_addr%0d got %h want %h", i, reqAddr[i], 4 + i); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_no_restart got busy %b want 0", busy); end
      memWait = 0;
      do_fetch(ip, 0);
      checks++; if (reqAddr[0] !== 32'h40) begin errors++; $display("FAIL ignored_new_ip got %h want 40", reqAddr[0]); end
      checks++; if (opcode !== expOpcode(32'h40)) begin errors++; $display("FAIL ignored_new_opcode got %h want %h", opcode, expOpcode(32'h40)); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] wantAddr;
      memWait = 0;
      do_fetch(32'hFFFF_FFFE, 0);
      for (int i = 0; i < NB; i++) begin
         wantAddr = 32'hFFFF_FFFE + AW'(i);
         checks++;
         if (reqAddr[i] !== wantAddr) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, reqAddr[i], wantAddr); end
      end
      checks++; if (opcode !== expOpcode(32'hFFFF_FFFE)) begin errors++; $display("FAIL wrap_opcode got %h want %h", opcode, expOpcode(32'hFFFF_FFFE)); end
   endtask

   task automatic test_random();
      logic [AW-1:0] ipVal;
      for (int t = 0; t < 8; t++) begin
         ipVal   = $urandom;
         memWait = $urandom_range(0, 3);
         do_fetch(ipVal, 0);
         checks++; if (opcode !== expOpcode(ipVal)) begin errors++; $display("FAIL rand%0d_opcode got %h want %h", t, opcode, expOpcode(ipVal)); end
         checks++; if (busyCount !== NB * (2 + memWait)) begin errors++; $display("FAIL rand%0d_cycles got %0d want %0d", t, busyCount, NB * (2 + memWait)); end
         checks++; if (reqCount !== NB || pulseBad) begin errors++; $display("FAIL rand%0d_reqs got %0d bad %b want %0d 0", t, reqCount, pulseBad, NB); end
      end
      memWait = 0;
   endtask

   task automatic test_back_to_back();
      int  cyc = 0;
      int  done = 0;
      int  lastFall = -1;
      bit  prevBusy = 0;
      memWait = 0;
      @(negedge clk);
      ip = 32'h0; start_loading = 1'b1;
      while (done < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (prevBusy && !busy) begin
            checks++; if (opcode !== expOpcode(ip)) begin errors++; $display("FAIL b2b%0d_opcode got %h want %h", done, opcode, expOpcode(ip)); end
            if (lastFall >= 0) begin
               checks++; if (cyc - lastFall !== 9) begin errors++; $display("FAIL b2b%0d_period got %0d want 9", done, cyc - lastFall); end
            end
            lastFall = cyc;
            done++;
            ip = ip + 32'h4;
            if (done == 3) start_loading = 1'b0;
         end
         prevBusy = busy;
      end
      checks++; if (done !== 3) begin errors++; $display("FAIL b2b_timeout got %0d fetches want 3", done); end
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy %b want 0", busy); end
   endtask

`ifdef OPCODE_BUFFER_HIT_EN
   task automatic test_hit();
      int reqs = 0;
      int busies = 0;
      do_fetch(32'h500, 0);
      @(negedge clk);
      start_loading = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (memBus.mem_request) reqs++;
         if (busy) busies++;
      end
      start_loading = 1'b0;
      checks++; if (reqs !== 0) begin errors++; $display("FAIL hit_requests got %0d want 0", reqs); end
      checks++; if (busies !== 0) begin errors++; $display("FAIL hit_busy got %0d want 0", busies); end
      checks++; if (opcode !== expOpcode(32'h500)) begin errors++; $display("FAIL hit_opcode got %h want %h", opcode, expOpcode(32'h500)); end
   endtask
`else
   task automatic test_refetch();
      do_fetch(32'h500, 0);
      do_fetch(32'h500, 0);
      checks++; if (busyCount !== 8 || reqCount !== NB) begin errors++; $display("FAIL refetch got cycles %0d reqs %0d want 8 %0d", busyCount, reqCount, NB); end
      checks++; if (opcode !== expOpcode(32'h500)) begin errors++; $display("FAIL refetch_opcode got %h want %h", opcode, expOpcode(32'h500)); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_reset_mid_fetch();
      test_wait_states();
      test_ignored_inputs();
      test_wrap();
      test_random();
      test_back_to_back();
`ifdef OPCODE_BUFFER_HIT_EN
      test_hit();
`else
      test_refetch();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
